// File: rtl/cosim_harness_pkg.sv
// Shared types and constants for the cosim vector harness.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cosim_harness_pkg;

    // Default vector width of the wrapped cosim DUT
    localparam int DEF_WIDTH = 128;

    // MISR feedback polynomial (x^128 + x^7 + x^2 + x + 1, top term implicit)
    localparam logic [127:0] MISR_POLY = 128'h87;

    // Harness sequencing states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_EMIT   = 2'd2
    } state_t;

endpackage

// File: rtl/cosim_misr.sv
// Combinational next-signature step of a Galois-style MISR.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller decides when to register the result.
module cosim_misr
    import cosim_harness_pkg::*;
#(
    parameter int               WIDTH = DEF_WIDTH,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(MISR_POLY)
) (
    input  logic [WIDTH-1:0] sig,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] next
);

    // Shift left, fold the outgoing MSB back through the polynomial, then mix in data
    always_comb begin
        next = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ data;
    end

endmodule

// File: rtl/cosim_vec_harness.sv
// Drives vectors into a combinational cosim DUT, samples after SETTLE cycles, signs results.
// Latency: SETTLE+1 cycles from vector accept to res_valid.
// Backpressure: result held in EMIT until res_ready; vec_ready low while busy unless EMIT drains.
module cosim_vec_harness
    import cosim_harness_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vec_valid,
    input  logic [WIDTH-1:0] vec_data,
    output logic             vec_ready,
    output logic [WIDTH-1:0] dut_in,
    input  logic [WIDTH-1:0] dut_out,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    input  logic             res_ready,
    input  logic             clear,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] vec_count,
    output logic             busy
);

    // Settle counter only needs to hold SETTLE-1
    localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [WIDTH-1:0] POLY = WIDTH'(MISR_POLY);

    state_t            state_q;
    state_t            state_d;
    logic [SC_W-1:0]   settle_cnt;
    logic              accept;
    logic              capture;
    logic [WIDTH-1:0]  sig_next;

    assign accept  = vec_valid & vec_ready;
    assign capture = (state_q == ST_SETTLE) && (settle_cnt == '0);

    cosim_misr #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_misr (
        .sig  (signature),
        .data (dut_out),
        .next (sig_next)
    );

    // State register; reset abandons any vector in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: EMIT can chain straight into SETTLE when a new vector is waiting
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_SETTLE;
            ST_SETTLE: if (settle_cnt == '0) state_d = ST_EMIT;
            ST_EMIT: begin
                if (res_ready) state_d = vec_valid ? ST_SETTLE : ST_IDLE;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; vec_ready deliberately ignores vec_valid
    always_comb begin
        res_valid = (state_q == ST_EMIT);
        busy      = (state_q != ST_IDLE);
        vec_ready = (state_q == ST_IDLE) || ((state_q == ST_EMIT) && res_ready);
    end

    // Vector drive, settle countdown and result capture; dut_in keeps its last vector in IDLE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dut_in     <= '0;
            res_data   <= '0;
            settle_cnt <= '0;
        end else begin
            if (accept) begin
                dut_in     <= vec_data;
                settle_cnt <= SC_W'(SETTLE - 1);
            end else if ((state_q == ST_SETTLE) && (settle_cnt != '0)) begin
                settle_cnt <= settle_cnt - SC_W'(1);
            end
            if (capture) begin
                res_data <= dut_out;
            end
        end
    end

    // Signature and saturating count; clear wins over a coincident capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            signature <= '0;
            vec_count <= '0;
        end else if (clear) begin
            signature <= '0;
            vec_count <= '0;
        end else if (capture) begin
            signature <= sig_next;
            if (vec_count != '1) begin
                vec_count <= vec_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cosim_vec_harness.sv
// Self-checking bench for cosim_vec_harness with a loopback DUT.
// Latency: expects results SETTLE+1 = 2 cycles after accept.
// Backpressure: exercises held results under res_ready=0 and back-to-back chaining.
module tb_cosim_vec_harness;

    localparam int W = 128;

    logic          clk;
    logic          rst_n;
    logic          vec_valid;
    logic [W-1:0]  vec_data;
    logic          vec_ready;
    logic [W-1:0]  dut_in;
    logic [W-1:0]  dut_out;
    logic          res_valid;
    logic [W-1:0]  res_data;
    logic          res_ready;
    logic          clear;
    logic [W-1:0]  signature;
    logic [31:0]   vec_count;
    logic          busy;

    int            n_cmp;
    int            n_err;
    logic [W-1:0]  sb_q[$];
    logic [W-1:0]  m_sig;
    logic [31:0]   m_cnt;

    // Loopback DUT
    assign dut_out = dut_in;

    cosim_vec_harness #(
        .WIDTH  (W),
        .SETTLE (1),
        .CNT_W  (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vec_valid (vec_valid),
        .vec_data  (vec_data),
        .vec_ready (vec_ready),
        .dut_in    (dut_in),
        .dut_out   (dut_out),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .clear     (clear),
        .signature (signature),
        .vec_count (vec_count),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference signature step written from the polynomial definition
    function automatic logic [W-1:0] ref_misr(input logic [W-1:0] s, input logic [W-1:0] d);
        logic [W-1:0] r;
        r = s << 1;
        if (s[W-1]) r = r ^ 128'h87;
        return r ^ d;
    endfunction

    // One clock; record an accepted vector in the scoreboard before the edge
    task automatic tick();
        if (rst_n && vec_valid && vec_ready) sb_q.push_back(vec_data);
        @(posedge clk);
        #1;
    endtask

    // Offer a vector until accepted (bounded); ok=0 on timeout
    task automatic push_vec(input logic [W-1:0] v, output bit ok);
        ok = 1'b0;
        vec_valid = 1'b1;
        vec_data  = v;
        for (int i = 0; i < 20; i++) begin
            if (vec_ready) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        vec_valid = 1'b0;
    endtask

    // Wait for res_valid (bounded); ok=0 on timeout
    task automatic wait_res(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Pop the expected loopback value; empty queue yields X so the compare fails
    function automatic logic [W-1:0] sb_pop();
        if (sb_q.size() == 0) return 'x;
        return sb_q.pop_front();
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; vec_valid = 1'b1; vec_data = 128'hdead_beef; res_ready = 1'b1; clear = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_cmp++; if (dut_in !== '0)     begin n_err++; $display("FAIL reset_dut_in got %h want 0", dut_in); end
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
        n_cmp++; if (res_data !== '0)   begin n_err++; $display("FAIL reset_res_data got %h want 0", res_data); end
        n_cmp++; if (signature !== '0)  begin n_err++; $display("FAIL reset_signature got %h want 0", signature); end
        n_cmp++; if (vec_count !== '0)  begin n_err++; $display("FAIL reset_vec_count got %0d want 0", vec_count); end
        n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (vec_ready !== 1'b1) begin n_err++; $display("FAIL reset_vec_ready got %b want 1", vec_ready); end
        vec_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_no_transfer busy got %b want 0", busy); end
        sb_q.delete();
        m_sig = '0; m_cnt = '0;
    endtask

    task automatic test_single();
        bit ok;
        logic [W-1:0] exp;
        res_ready = 1'b0;
        push_vec(128'h1, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL single_accept timeout"); end
        // Cycle n+1: dut_in visible, result not yet valid
        n_cmp++; if (dut_in !== 128'h1) begin n_err++; $display("FAIL single_dut_in got %h want 1", dut_in); end
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid got %b want 0", res_valid); end
        tick();
        // Cycle n+2: result valid and signed
        n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", res_valid); end
        exp = sb_pop();
        m_sig = ref_misr(m_sig, exp); m_cnt++;
        n_cmp++; if (res_data !== exp) begin n_err++; $display("FAIL single_res_data got %h want %h", res_data, exp); end
        n_cmp++; if (signature !== 128'h1) begin n_err++; $display("FAIL single_signature got %h want 1", signature); end
        n_cmp++; if (vec_count !== 32'd1) begin n_err++; $display("FAIL single_vec_count got %0d want 1", vec_count); end
        res_ready = 1'b1;
        tick();
        n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL single_drain valid %b busy %b want 0 0", res_valid, busy); end
    endtask

    task automatic test_misr();
        bit ok;
        logic [W-1:0] exp;
        logic [W-1:0] top_bit;
        logic [W-1:0] want;
        top_bit = 128'h1 << 127;
        clear = 1'b1; tick(); clear = 1'b0;
        m_sig = '0; m_cnt = '0;
        res_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            push_vec((k == 0) ? top_bit : '0, ok);
            wait_res(ok);
            n_cmp++; if (!ok) begin n_err++; $display("FAIL misr_wait%0d timeout", k); end
            exp = sb_pop();
            m_sig = ref_misr(m_sig, exp); m_cnt++;
            want = (k == 0) ? top_bit : 128'h87;
            n_cmp++; if (res_data !== exp) begin n_err++; $display("FAIL misr_res_data%0d got %h want %h", k, res_data, exp); end
            n_cmp++; if (signature !== want) begin n_err++; $display("FAIL misr_signature%0d got %h want %h", k, signature, want); end
            n_cmp++; if (signature !== m_sig) begin n_err++; $display("FAIL misr_model%0d got %h want %h", k, signature, m_sig); end
            tick();
        end
        n_cmp++; if (vec_count !== 32'd2) begin n_err++; $display("FAIL misr_vec_count got %0d want 2", vec_count); end
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
        b = 128'h5a5a_0000_ffff_1111_2222_3333_4444_a5a5;
        res_ready = 1'b0;
        push_vec(a, ok);
        wait_res(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL bp_wait timeout"); end
        void'(sb_pop());
        m_sig = ref_misr(m_sig, a); m_cnt++;
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid%0d got %b want 1", i, res_valid); end
            n_cmp++; if (res_data !== a) begin n_err++; $display("FAIL bp_hold_data%0d got %h want %h", i, res_data, a); end
            n_cmp++; if (dut_in !== a) begin n_err++; $display("FAIL bp_hold_dut_in%0d got %h want %h", i, dut_in, a); end
            n_cmp++; if (vec_ready !== 1'b0) begin n_err++; $display("FAIL bp_vec_ready%0d got %b want 0", i, vec_ready); end
            tick();
        end
        // Drain and accept the next vector in the same cycle
        vec_valid = 1'b1; vec_data = b; res_ready = 1'b1;
        #1;
        n_cmp++; if (vec_ready !== 1'b1) begin n_err++; $display("FAIL bp_chain_ready got %b want 1", vec_ready); end
        tick();
        vec_valid = 1'b0; res_ready = 1'b0;
        n_cmp++; if (res_valid !== 1'b0 || dut_in !== b) begin n_err++; $display("FAIL bp_chain_settle valid %b dut_in %h want 0 %h", res_valid, dut_in, b); end
        tick();
        n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL bp_chain_valid got %b want 1", res_valid); end
        void'(sb_pop());
        m_sig = ref_misr(m_sig, b); m_cnt++;
        n_cmp++; if (res_data !== b) begin n_err++; $display("FAIL bp_chain_data got %h want %h", res_data, b); end
        n_cmp++; if (signature !== m_sig || vec_count !== m_cnt) begin n_err++; $display("FAIL bp_sig got %h/%0d want %h/%0d", signature, vec_count, m_sig, m_cnt); end
        res_ready = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp;
        int sent;
        int got;
        int last_t;
        bit acc;
        res_ready = 1'b1;
        sent = 0; got = 0; last_t = 0;
        vec_valid = 1'b1;
        vec_data  = {4{$urandom()}};
        for (int t = 1; t <= 30; t++) begin
            acc = vec_valid && vec_ready;
            tick();
            if (acc) begin
                sent++;
                if (sent == 4) vec_valid = 1'b0;
                else vec_data = {4{$urandom()}};
            end
            if (res_valid) begin
                got++; last_t = t;
                exp = sb_pop();
                m_sig = ref_misr(m_sig, exp); m_cnt++;
                n_cmp++; if (res_data !== exp) begin n_err++; $display("FAIL b2b_data%0d got %h want %h", got, res_data, exp); end
                n_cmp++; if (signature !== m_sig) begin n_err++; $display("FAIL b2b_sig%0d got %h want %h", got, signature, m_sig); end
                n_cmp++; if (vec_count !== m_cnt) begin n_err++; $display("FAIL b2b_cnt%0d got %0d want %0d", got, vec_count, m_cnt); end
            end
        end
        n_cmp++; if (got != 4) begin n_err++; $display("FAIL b2b_results got %0d want 4", got); end
        n_cmp++; if (last_t != 8) begin n_err++; $display("FAIL b2b_throughput last at %0d want 8", last_t); end
    endtask

    task automatic test_clear_collision();
        bit ok;
        res_ready = 1'b0;
        push_vec(128'h5, ok);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        void'(sb_pop());
        m_sig = '0; m_cnt = '0;
        n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL clr_valid got %b want 1", res_valid); end
        n_cmp++; if (res_data !== 128'h5) begin n_err++; $display("FAIL clr_res_data got %h want 5", res_data); end
        n_cmp++; if (signature !== '0) begin n_err++; $display("FAIL clr_signature got %h want 0", signature); end
        n_cmp++; if (vec_count !== '0) begin n_err++; $display("FAIL clr_vec_count got %0d want 0", vec_count); end
        res_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen;
        res_ready = 1'b1;
        push_vec(128'h9, ok);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rmid_settle busy got %b want 1", busy); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sb_q.delete();
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (res_valid) seen = 1'b1;
            tick();
        end
        n_cmp++; if (seen) begin n_err++; $display("FAIL rmid_res_valid got 1 want 0"); end
        n_cmp++; if (vec_count !== '0) begin n_err++; $display("FAIL rmid_vec_count got %0d want 0", vec_count); end
        n_cmp++; if (busy !== 1'b0 || vec_ready !== 1'b1) begin n_err++; $display("FAIL rmid_idle busy %b ready %b want 0 1", busy, vec_ready); end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; vec_valid = 1'b0; vec_data = '0; res_ready = 1'b0; clear = 1'b0;
        m_sig = '0; m_cnt = '0;
        test_reset();
        test_single();
        test_misr();
        test_backpressure();
        test_back_to_back();
        test_clear_collision();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
